// File: rtl/conv_window_mac_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : conv_window_mac_pkg
//  Purpose  : Shared constants, FSM state encoding and byte-select helpers
//             for the 2x2-over-4x4 valid-mode convolution engine.
//  Contents : KDIM, IDIM, ACC_W, N_OUT, LAST_K, state_e,
//             pix_sel(), wgt_sel(), k_row(), k_col()
//  Revision : 1.0  initial release
// ============================================================================
package conv_window_mac_pkg;

  localparam int KDIM  = 2;   // kernel side, fixed by the datapath
  localparam int IDIM  = 4;   // image side, fixed by the datapath
  localparam int ACC_W = 18;  // 4*255*255 = 260100 fits without wrap
  localparam int N_OUT = (IDIM - KDIM + 1) * (IDIM - KDIM + 1);

  localparam logic [3:0] LAST_K = 4'(N_OUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // p(r,c) sits at byte 4r+c; with IDIM=4 that byte index is just {r,c}.
  function automatic logic [7:0] pix_sel(input logic [127:0] img,
                                         input logic [1:0]   r,
                                         input logic [1:0]   c);
    return img[{r, c, 3'b000} +: 8];
  endfunction

  // w(i,j) sits at byte 2i+j, i.e. {i,j}.
  function automatic logic [7:0] wgt_sel(input logic [31:0] w,
                                         input logic        i,
                                         input logic        j);
    return w[{i, j, 3'b000} +: 8];
  endfunction

  // Output index k = 3r+c split back into window origin (r,c).
  function automatic logic [1:0] k_row(input logic [3:0] k);
    if (k < 4'd3)      return 2'd0;
    else if (k < 4'd6) return 2'd1;
    else               return 2'd2;
  endfunction

  function automatic logic [1:0] k_col(input logic [3:0] k);
    case (k)
      4'd0, 4'd3, 4'd6: return 2'd0;
      4'd1, 4'd4, 4'd7: return 2'd1;
      default:          return 2'd2;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv_mac.sv
`default_nettype none
// ============================================================================
//  Module   : conv_mac
//  Purpose  : 8x8 unsigned multiply feeding an 18-bit accumulator.
//  Ports    : clk, rst   - clock, synchronous active-high reset
//             clr_i      - zero the accumulator (wins over en_i)
//             en_i       - accumulate a_i*b_i this edge
//             a_i, b_i   - unsigned 8-bit operands
//             sum_o      - acc + a_i*b_i (combinational, pre-register)
//  Revision : 1.0  initial release
// ============================================================================
module conv_mac
  import conv_window_mac_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [7:0]       a_i,
  input  logic [7:0]       b_i,
  output logic [ACC_W-1:0] sum_o
);

  logic [ACC_W-1:0] acc_q;
  logic [15:0]      prod;

  assign prod  = 16'(a_i) * 16'(b_i);
  // Exposing the pre-register sum lets the owner capture the final tap's
  // result on the same edge the last product is accumulated.
  assign sum_o = acc_q + ACC_W'(prod);

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= sum_o;
    end
  end

endmodule
`default_nettype wire

// File: rtl/conv_window_mac.sv
`default_nettype none
// ============================================================================
//  Module   : conv_window_mac
//  Purpose  : Sequential 2x2 valid-mode convolution over a 4x4 byte image,
//             one shared MAC, one tap per cycle, nine 18-bit results
//             presented on a valid/ready port.
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             start               - run request, honoured only when idle
//             weights[31:0]       - kernel, w(i,j) at byte 2i+j
//             data[127:0]         - image,  p(r,c) at byte 4r+c
//             busy                - run in progress
//             out_valid/out_ready - result handshake
//             out_data[17:0]      - result y(r,c)
//             out_index[3:0]      - k = 3r+c of the presented result
//             done                - one-cycle pulse after last transfer
//  Revision : 1.0  initial release
// ============================================================================
module conv_window_mac
  import conv_window_mac_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      weights,
  input  logic [127:0]     data,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic [3:0]       out_index,
  output logic             done
);

  state_e state_q, state_d;

  logic [31:0]      wgt_q;
  logic [127:0]     img_q;
  logic [3:0]       k_q;
  logic [1:0]       tap_q;
  logic             busy_q;
  logic             valid_q;
  logic             done_q;
  logic [ACC_W-1:0] res_q;

  // FSM control strobes
  logic snap;
  logic mac_clr;
  logic mac_en;
  logic load_out;
  logic xfer;

  // Tap addressing: window origin plus tap offset (i = tap[1], j = tap[0]).
  logic [1:0]       pix_r;
  logic [1:0]       pix_c;
  logic [7:0]       op_w;
  logic [7:0]       op_p;
  logic [ACC_W-1:0] mac_sum;

  assign pix_r = k_row(k_q) + {1'b0, tap_q[1]};
  assign pix_c = k_col(k_q) + {1'b0, tap_q[0]};
  assign op_w  = wgt_sel(wgt_q, tap_q[1], tap_q[0]);
  assign op_p  = pix_sel(img_q, pix_r, pix_c);

  conv_mac u_mac (
    .clk   (clk),
    .rst   (rst),
    .clr_i (mac_clr),
    .en_i  (mac_en),
    .a_i   (op_w),
    .b_i   (op_p),
    .sum_o (mac_sum)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    snap     = 1'b0;
    mac_clr  = 1'b0;
    mac_en   = 1'b0;
    load_out = 1'b0;
    xfer     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          snap    = 1'b1;
          mac_clr = 1'b1;
          state_d = ST_MAC;
        end
      end
      ST_MAC: begin
        mac_en = 1'b1;
        if (tap_q == 2'd3) begin
          load_out = 1'b1;
          state_d  = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // out_valid is always high in HOLD, so ready alone completes it.
        if (out_ready) begin
          xfer    = 1'b1;
          mac_clr = 1'b1;
          state_d = (k_q == LAST_K) ? ST_IDLE : ST_MAC;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wgt_q   <= '0;
      img_q   <= '0;
      k_q     <= '0;
      tap_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      done_q <= 1'b0;
      if (snap) begin
        wgt_q  <= weights;
        img_q  <= data;
        k_q    <= '0;
        tap_q  <= '0;
        busy_q <= 1'b1;
      end
      if (mac_en) begin
        tap_q <= tap_q + 2'd1;
      end
      if (load_out) begin
        res_q   <= mac_sum;
        valid_q <= 1'b1;
      end
      if (xfer) begin
        valid_q <= 1'b0;
        tap_q   <= '0;
        if (k_q == LAST_K) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end else begin
          k_q <= k_q + 4'd1;
        end
      end
    end
  end

  assign busy      = busy_q;
  assign out_valid = valid_q;
  assign out_data  = res_q;
  assign out_index = k_q;
  assign done      = done_q;

endmodule
`default_nettype wire
